// File: rtl/multiplicador_seq.sv
// ---------------------------------------------------------------------------
// multiplicador_seq
// Sequential shift-add multiplier. Each accepted request multiplies two
// WIDTH-bit operands over WIDTH clock cycles, handling one multiplier bit
// per cycle (LSB first). The result is stored in a register that holds the
// last completed product.
//
// Optional feature macro: MULT_SIGNED_EN
//   Defined   -> adds the signed_op port. signed_op=1 at the accepting edge
//                selects a two's complement multiply.
//   Undefined -> only unsigned operation; no sign-handling logic exists.
//
// Ports:
//   clk           in   system clock; all state changes on its rising edge
//   reset         in   asynchronous reset, active high
//   start         in   request; accepted when the block is in IDLE or DONE
//   multiplicando in   [WIDTH-1:0] multiplicand, sampled on the accepting edge
//   multiplicador in   [WIDTH-1:0] multiplier, sampled on the accepting edge
//   signed_op     in   operand mode (only when MULT_SIGNED_EN is defined)
//   produto       out  [2*WIDTH-1:0] last completed product, registered
//   busy          out  high while a multiplication is running
//   done          out  one-cycle pulse marking a new produto value
// ---------------------------------------------------------------------------
module multiplicador_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicando,
    input  logic [WIDTH-1:0]     multiplicador,
`ifdef MULT_SIGNED_EN
    input  logic                 signed_op,
`endif
    output logic [2*WIDTH-1:0]   produto,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               stateReg;
    state_t               stateNext;

    logic [2*WIDTH-1:0]   mcandReg;
    logic [WIDTH-1:0]     mplierReg;
    logic [2*WIDTH-1:0]   accReg;
    logic [CW-1:0]        bitCount;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   sumNext;
    logic [2*WIDTH-1:0]   mcandExt;
    logic                 accept;
    logic                 lastStep;

`ifdef MULT_SIGNED_EN
    logic                 signedReg;
`endif

    // A request is only honoured when no multiplication is running.
    assign accept   = start && ((stateReg == IDLE) || (stateReg == DONE));
    assign lastStep = (stateReg == CALC) && (bitCount == LAST_BIT);

    // The multiplicand is kept 2*WIDTH wide so it can be shifted left into
    // the upper half of the product. In signed mode it is sign-extended.
`ifdef MULT_SIGNED_EN
    assign mcandExt = {{WIDTH{signed_op & multiplicando[WIDTH-1]}}, multiplicando};
`else
    assign mcandExt = {{WIDTH{1'b0}}, multiplicando};
`endif

    // One shift-add step. For a two's complement multiplier the MSB carries
    // weight -2^(WIDTH-1), so its partial product is subtracted instead of
    // added; the result stays exact modulo 2^(2*WIDTH).
    always_comb begin
        partial = mplierReg[0] ? mcandReg : '0;
        sumNext = accReg + partial;
`ifdef MULT_SIGNED_EN
        if (signedReg && (bitCount == LAST_BIT)) begin
            sumNext = accReg - partial;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic. DONE lasts one cycle, unless a new request arrives,
    // which sends the block straight back into CALC.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start) stateNext = CALC;
            CALC:    if (bitCount == LAST_BIT) stateNext = DONE;
            DONE:    stateNext = start ? CALC : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Status outputs are decoded purely from the state register.
    assign busy = (stateReg == CALC);
    assign done = (stateReg == DONE);

    // Datapath. Operands are latched on the accepting edge, so later input
    // changes do not affect the multiplication in progress. produto is
    // written only on the final step; it keeps the previous result while
    // CALC runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcandReg  <= '0;
            mplierReg <= '0;
            accReg    <= '0;
            bitCount  <= '0;
            produto   <= '0;
`ifdef MULT_SIGNED_EN
            signedReg <= 1'b0;
`endif
        end else if (accept) begin
            mcandReg  <= mcandExt;
            mplierReg <= multiplicador;
            accReg    <= '0;
            bitCount  <= '0;
`ifdef MULT_SIGNED_EN
            signedReg <= signed_op;
`endif
        end else if (stateReg == CALC) begin
            accReg    <= sumNext;
            mcandReg  <= mcandReg << 1;
            mplierReg <= mplierReg >> 1;
            bitCount  <= bitCount + CW'(1);
            if (lastStep) begin
                produto <= sumNext;
            end
        end
    end

endmodule

// File: tb/tb_multiplicador_seq.sv
// ---------------------------------------------------------------------------
// tb_multiplicador_seq
// Self-checking bench for multiplicador_seq with WIDTH=16. A table of
// operand pairs with hand-computed products is run through the block. Short
// scripted sequences then cover the multi-cycle cases: start ignored during
// CALC, start held high, reset in mid-operation, start present when reset
// is released, and signed mode when MULT_SIGNED_EN is defined.
// Inputs are driven on the falling edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_multiplicador_seq;

    localparam int W = 16;

    logic            clk;
    logic            reset;
    logic            start;
    logic [W-1:0]    multiplicando;
    logic [W-1:0]    multiplicador;
`ifdef MULT_SIGNED_EN
    logic            signedOp;
`endif
    logic [2*W-1:0]  produto;
    logic            busy;
    logic            done;

    int checks;
    int errors;
    logic [2*W-1:0] prevProd;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
    } vec_t;

    vec_t vecs[10];

    multiplicador_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .multiplicando (multiplicando),
        .multiplicador (multiplicador),
`ifdef MULT_SIGNED_EN
        .signed_op     (signedOp),
`endif
        .produto       (produto),
        .busy          (busy),
        .done          (done)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one value and reports a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents a request on the falling edge, waits for the accepting edge,
    // then drops start and zeroes the operands. The operands are captured
    // inside the block, so zeroing them must not change the result.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        multiplicando = a;
        multiplicador = b;
        start         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start         = 1'b0;
        multiplicando = '0;
        multiplicador = '0;
    endtask

    // Runs one complete multiplication and checks its timing and result.
    task automatic runVector(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] expProd, input string name);
        applyStimulus(a, b);
        checkOutput({name, " busy@E0+0"}, 64'(busy), 64'd1);
        checkOutput({name, " done@E0+0"}, 64'(done), 64'd0);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (k == W - 1) begin
                checkOutput({name, " hold@E0+15"}, 64'(produto), 64'(prevProd));
                checkOutput({name, " done@E0+15"}, 64'(done), 64'd0);
            end
        end
        checkOutput({name, " done@E0+16"}, 64'(done), 64'd1);
        checkOutput({name, " busy@E0+16"}, 64'(busy), 64'd0);
        checkOutput({name, " produto"}, 64'(produto), 64'(expProd));
        @(negedge clk);
        checkOutput({name, " done@E0+17"}, 64'(done), 64'd0);
        prevProd = expProd;
    endtask

    initial begin
        int doneCount;

        checks        = 0;
        errors        = 0;
        prevProd      = '0;
        start         = 1'b0;
        multiplicando = '0;
        multiplicador = '0;
`ifdef MULT_SIGNED_EN
        signedOp      = 1'b0;
`endif

        vecs[0] = '{16'd12,   16'd75,   32'h0000_0384};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h0FA1, 16'h07D1, 32'h007A_2971};
        vecs[3] = '{16'h0000, 16'h1234, 32'h0000_0000};
        vecs[4] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
        vecs[5] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
        vecs[7] = '{16'h00FF, 16'h0100, 32'h0000_FF00};
        vecs[8] = '{16'h1234, 16'h0010, 32'h0001_2340};
        vecs[9] = '{16'd16,   16'd5,    32'h0000_0050};

        // Reset state.
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset produto", 64'(produto), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        reset = 1'b0;

        // Table of directed vectors.
        for (int i = 0; i < 10; i++) begin
            runVector(vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));
        end

        // A second start pulse during CALC must be ignored.
        doneCount = 0;
        applyStimulus(16'h0003, 16'h0007);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 4) begin
                start         = 1'b1;
                multiplicando = 16'h00FF;
                multiplicador = 16'h00FF;
            end
            if (k == 5) begin
                start         = 1'b0;
                multiplicando = '0;
                multiplicador = '0;
            end
            if (k == 15) checkOutput("ignore hold@E0+15", 64'(produto), 64'(prevProd));
            if (k == 16) begin
                checkOutput("ignore done@E0+16", 64'(done), 64'd1);
                checkOutput("ignore produto", 64'(produto), 64'h15);
            end
            if (done) doneCount++;
        end
        checkOutput("ignore done count", 64'(doneCount), 64'd1);
        prevProd = 32'h15;

        // Start held high: back-to-back operations every 17 cycles.
        doneCount = 0;
        @(negedge clk);
        multiplicando = 16'd16;
        multiplicador = 16'd5;
        start         = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 52; k++) begin
            @(negedge clk);
            if (done) doneCount++;
            if (k == 16 || k == 33 || k == 50) begin
                checkOutput($sformatf("held done@E0+%0d", k), 64'(done), 64'd1);
                checkOutput($sformatf("held produto@E0+%0d", k), 64'(produto), 64'h50);
            end
            if (k == 50) start = 1'b0;
        end
        checkOutput("held done count", 64'(doneCount), 64'd3);
        checkOutput("held idle busy", 64'(busy), 64'd0);
        prevProd = 32'h50;

        // Reset in mid-operation aborts immediately with no later done.
        applyStimulus(16'h1111, 16'h0003);
        for (int k = 1; k <= 8; k++) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort produto", 64'(produto), 64'd0);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        doneCount = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("abort no done", 64'(doneCount), 64'd0);
        prevProd = '0;

        // Start already high when reset is released.
        reset         = 1'b1;
        start         = 1'b1;
        multiplicando = 16'd9;
        multiplicador = 16'd9;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rststart busy", 64'(busy), 64'd1);
        start         = 1'b0;
        multiplicando = '0;
        multiplicador = '0;
        for (int k = 1; k <= W; k++) @(negedge clk);
        checkOutput("rststart done", 64'(done), 64'd1);
        checkOutput("rststart produto", 64'(produto), 64'h51);
        @(negedge clk);
        prevProd = 32'h51;

`ifdef MULT_SIGNED_EN
        // Signed mode, then the same operands unsigned.
        signedOp = 1'b1;
        runVector(16'hFFFD, 16'h0005, 32'hFFFF_FFF1, "signed -3*5");
        runVector(16'hFFFF, 16'hFFFF, 32'h0000_0001, "signed -1*-1");
        runVector(16'h0005, 16'hFFFD, 32'hFFFF_FFF1, "signed 5*-3");
        signedOp = 1'b0;
        runVector(16'hFFFD, 16'h0005, 32'h0004_FFF1, "unsigned 0xFFFD*5");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplicador_seq.md
MULTIPLICADOR_SEQ -- requirements
Module: multiplicador_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 4..32.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request; sampled on a rising edge when the block is in IDLE or DONE.
REQ-005 Multiplicando  input  WIDTH  multiplicand; sampled only on the accepting edge.
REQ-006 Multiplicador  input  WIDTH  multiplier; sampled only on the accepting edge.
REQ-007 Signed  input  1  operand mode, sampled on the accepting edge; present only with MULT_SIGNED_EN.
REQ-008 Produto  output  2*WIDTH  last completed product, registered.
REQ-009 Busy  output  1  high while a multiplication is in progress.
REQ-010 Done  output  1  one-cycle pulse marking a new valid Produto.

Function
REQ-011 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-012 Transitions SHALL be: IDLE->CALC on Start; CALC->DONE when the bit counter reaches WIDTH-1; DONE->CALC on Start; DONE->IDLE otherwise.
REQ-013 The accepting edge E0 SHALL capture both operands and the mode into internal registers, clear the accumulator and counter, enter CALC, and set Busy=1.
REQ-014 CALC SHALL perform one shift-add step per clock, i.e. one multiplier bit per edge, LSB first, for exactly WIDTH edges.
REQ-015 At edge E0+WIDTH the block SHALL write the full 2*WIDTH product to Produto, set Done=1 and Busy=0, and enter DONE.
REQ-016 Done SHALL be high for exactly one cycle; it SHALL return to 0 at edge E0+WIDTH+1.
REQ-017 Produto SHALL hold the previous result throughout CALC and SHALL change only at the completion edge or on reset.
REQ-018 The result SHALL be exact modulo 2^(2*WIDTH); no overflow is possible.
REQ-019 Start while in CALC SHALL be ignored; the current operation SHALL continue unchanged.
REQ-020 Start asserted in DONE SHALL be accepted (back-to-back), giving a throughput of one result per WIDTH+1 cycles.
REQ-021 Operand input changes after E0 SHALL NOT affect the result in progress.
REQ-022 Start held continuously high SHALL restart the block at every DONE state.
REQ-023 Busy and Done SHALL be decoded directly from registered state, with no combinational path from any input.

Reset
REQ-024 While Reset=1, regardless of clock, the state SHALL be IDLE, with Produto=0, Busy=0, Done=0, and the counter, accumulator and operand registers all 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation, and no Done pulse SHALL be produced for the aborted operation.
REQ-026 If Start is high when Reset deasserts, it SHALL be accepted on the first rising edge after deassertion.

Configuration
REQ-027 The macro MULT_SIGNED_EN SHALL control signed operation.
REQ-028 With MULT_SIGNED_EN defined:
- the Signed port SHALL exist;
- Signed=1 at E0 SHALL treat both operands as two's complement and produce the signed 2*WIDTH product;
- latency SHALL be identical to unsigned mode;
- Signed=0 SHALL behave exactly as unsigned.
REQ-029 Without MULT_SIGNED_EN:
- the Signed port SHALL be absent;
- all operands SHALL be unsigned;
- the sign-handling logic SHALL NOT be synthesised.

Verification (WIDTH=16)
REQ-030 Reset=1 for one cycle, then Start=1 with 12 and 75 -> Busy=1 after E0; Done=1 and Produto=0x00000384 after E0+16; Done=0 after E0+17.
REQ-031 Start with 0xFFFF and 0xFFFF -> Produto=0xFFFE0001 at E0+16; operands changed to 0 at E0+1 -> Produto=0x007A2971 for a subsequent 0x0FA1 * 0x07D1 run, with the result unaffected by the operand change.
REQ-032 Second Start pulsed at E0+5 during CALC -> ignored; a single Done at E0+16; Produto still holds the previous value at E0+15.
REQ-033 Start held high continuously with 16 and 5 -> Produto=0x00000050, with Done pulses at E0+16, E0+33 and E0+50.
REQ-034 Reset pulsed at E0+8 -> Produto=0, Busy=0, Done=0 immediately; no Done pulse follows.
REQ-035 MULT_SIGNED_EN defined, Signed=1, operands 0xFFFD (-3) and 0x0005 -> Produto=0xFFFFFFF1 at E0+16; the same operands with Signed=0 -> Produto=0x0004FFF1.
